mem_port_responder: RTL and testbench



---
 rtl/mem_port_responder.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_responder.sv
// Four-port memory responder: 128x8 unified RAM, one port served per request.
// Ports: clk, rst_n (sync active-low), en/sel request, readN/writeN/addressN/
// input_dataN per port, output_dataN read registers, ready pulse, busy,
// dispN display mirrors, err (only when WRITE_GUARD_EN is defined).
module mem_port_responder #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int LATENCY   = 1,
  parameter int DISP_BASE = 28,
  parameter int PROG_BASE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        sel,
  input  logic              read0,
  input  logic              read1,
  input  logic              read2,
  input  logic              read3,
  input  logic              write0,
  input  logic              write1,
  input  logic              write2,
  input  logic              write3,
  input  logic [ADDR_W-1:0] address0,
  input  logic [ADDR_W-1:0] address1,
  input  logic [ADDR_W-1:0] address2,
  input  logic [ADDR_W-1:0] address3,
  input  logic [DATA_W-1:0] input_data0,
  input  logic [DATA_W-1:0] input_data1,
  input  logic [DATA_W-1:0] input_data2,
  input  logic [DATA_W-1:0] input_data3,
  output logic [DATA_W-1:0] output_data0,
  output logic [DATA_W-1:0] output_data1,
  output logic [DATA_W-1:0] output_data2,
  output logic [DATA_W-1:0] output_data3,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] disp0,
  output logic [DATA_W-1:0] disp1,
  output logic [DATA_W-1:0] disp2,
  output logic [DATA_W-1:0] disp3
`ifdef WRITE_GUARD_EN
  ,output logic             err
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t state, state_nx;
  logic [7:0] cnt;

  logic [1:0]        c_sel;
  logic              c_rd, c_wr;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;

  logic              p_rd, p_wr;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] odata [4];
  logic [DATA_W-1:0] disp [4];

  logic fire, blocked, commit;

  always_comb begin
    p_rd   = read0;
    p_wr   = write0;
    p_addr = address0;
    p_data = input_data0;
    unique case (sel)
      2'd0: begin
        p_rd = read0; p_wr = write0;
        p_addr = address0; p_data = input_data0;
      end
      2'd1: begin
        p_rd = read1; p_wr = write1;
        p_addr = address1; p_data = input_data1;
      end
      2'd2: begin
        p_rd = read2; p_wr = write2;
        p_addr = address2; p_data = input_data2;
      end
      2'd3: begin
        p_rd = read3; p_wr = write3;
        p_addr = address3; p_data = input_data3;
      end
      default: ;
    endcase
  end

  assign fire = (state == ACCESS) && (cnt == 8'd0);

`ifdef WRITE_GUARD_EN
  localparam logic [ADDR_W-1:0] PROG_A = ADDR_W'(PROG_BASE);
  logic err_q;
  // Fetch port may load program space; data ports may not.
  assign blocked = c_wr && (c_sel != 2'd0) && (c_addr >= PROG_A);
  assign err     = (state == RESP) && err_q;
`else
  assign blocked = 1'b0;
`endif

  assign commit = fire && c_wr && !blocked;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en) state_nx = ACCESS;
      ACCESS:  if (cnt == 8'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      c_sel  <= '0;
      c_rd   <= 1'b0;
      c_wr   <= 1'b0;
      c_addr <= '0;
      c_data <= '0;
      for (int k = 0; k < 4; k++) begin
        odata[k] <= '0;
        disp[k]  <= '0;
      end
`ifdef WRITE_GUARD_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && en) begin
        c_sel  <= sel;
        c_rd   <= p_rd;
        c_wr   <= p_wr;
        c_addr <= p_addr;
        c_data <= p_data;
        cnt    <= CNT_INIT;
      end
      if (state == ACCESS && cnt != 8'd0)
        cnt <= cnt - 8'd1;
      if (fire) begin
`ifdef WRITE_GUARD_EN
        err_q <= blocked;
`endif
        // Write-through: a committed write returns its own data.
        if (c_rd)
          odata[c_sel] <= commit ? c_data : mem[c_addr];
        if (commit)
          for (int k = 0; k < 4; k++)
            if (c_addr == ADDR_W'(DISP_BASE + k))
              disp[k] <= c_data;
      end
    end
  end

  // RAM is not reset; rst_n gating aborts an in-flight write.
  always_ff @(posedge clk) begin
    if (rst_n && commit)
      mem[c_addr] <= c_data;
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);

  assign output_data0 = odata[0];
  assign output_data1 = odata[1];
  assign output_data2 = odata[2];
  assign output_data3 = odata[3];
  assign disp0 = disp[0];
  assign disp1 = disp[1];
  assign disp2 = disp[2];
  assign disp3 = disp[3];

endmodule

// File: tb/tb_mem_port_responder.sv
// Randomized bench for mem_port_responder against a behavioural memory model.
// Ports driven per-port from arrays; guard checks only with WRITE_GUARD_EN.
module tb_mem_port_responder;

  localparam int LAT = 3;
  localparam int P   = LAT + 2;

`ifdef WRITE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [1:0] sel;
  logic [3:0] rd_v, wr_v;
  logic [6:0] ad_v [4];
  logic [7:0] di_v [4];
  logic [7:0] od [4];
  logic [7:0] dp [4];
  logic ready, busy;
`ifdef WRITE_GUARD_EN
  logic err;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] m [128];
  logic [7:0] od_m [4];
  logic [7:0] dp_m [4];
  logic exp_err;

  always #5 clk = ~clk;

  mem_port_responder #(
    .ADDR_W(7), .DATA_W(8), .LATENCY(LAT),
    .DISP_BASE(28), .PROG_BASE(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
    .read0(rd_v[0]), .read1(rd_v[1]),
    .read2(rd_v[2]), .read3(rd_v[3]),
    .write0(wr_v[0]), .write1(wr_v[1]),
    .write2(wr_v[2]), .write3(wr_v[3]),
    .address0(ad_v[0]), .address1(ad_v[1]),
    .address2(ad_v[2]), .address3(ad_v[3]),
    .input_data0(di_v[0]), .input_data1(di_v[1]),
    .input_data2(di_v[2]), .input_data3(di_v[3]),
    .output_data0(od[0]), .output_data1(od[1]),
    .output_data2(od[2]), .output_data3(od[3]),
    .ready(ready), .busy(busy),
    .disp0(dp[0]), .disp1(dp[1]),
    .disp2(dp[2]), .disp3(dp[3])
`ifdef WRITE_GUARD_EN
    ,.err(err)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_od%0d", tag, k), 32'(od[k]), 32'(od_m[k]));
      chk($sformatf("%s_dp%0d", tag, k), 32'(dp[k]), 32'(dp_m[k]));
    end
  endtask

  task automatic scramble();
    for (int k = 0; k < 4; k++) begin
      rd_v[k] = 1'($urandom);
      wr_v[k] = 1'($urandom);
      ad_v[k] = 7'($urandom);
      di_v[k] = 8'($urandom);
    end
  endtask

  // Reference: spec rules applied directly to the model arrays.
  task automatic model(input logic [1:0] s, input logic r, w,
                       input logic [6:0] a, input logic [7:0] d);
    logic blk;
    blk = GUARD && w && (s != 2'd0) && (a >= 7'd32);
    if (w && !blk) begin
      m[a] = d;
      if (a >= 7'd28 && a <= 7'd31) dp_m[a - 7'd28] = d;
    end
    if (r) od_m[s] = m[a];
    exp_err = blk;
  endtask

  task automatic do_txn(input logic [1:0] s, input logic r, w,
                        input logic [6:0] a, input logic [7:0] d,
                        input string tag);
    int n;
    @(negedge clk);
    scramble();
    rd_v[s] = r; wr_v[s] = w;
    ad_v[s] = a; di_v[s] = d;
    sel = s; en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    scramble();
    model(s, r, w, a, d);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(LAT));
    chk_outs(tag);
`ifdef WRITE_GUARD_EN
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
`endif
    @(negedge clk);
    chk({tag, "_rdyoff"}, 32'(ready), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses;
    logic seen;
    logic [1:0] s;
    logic [6:0] a;
    rst_n = 1'b0; en = 1'b0; sel = '0;
    rd_v = '0; wr_v = '0;
    for (int k = 0; k < 4; k++) begin
      ad_v[k] = '0; di_v[k] = '0;
      od_m[k] = '0; dp_m[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_outs("rst");
    rst_n = 1'b1;

    // Directed: write then read through port 1.
    do_txn(2'd1, 1'b0, 1'b1, 7'd5, 8'hA5, "wr5");
    do_txn(2'd1, 1'b1, 1'b0, 7'd5, 8'h00, "rd5");

    // Preload whole RAM through fetch port so the model is exact.
    for (int i = 0; i < 128; i++)
      do_txn(2'd0, 1'b0, 1'b1, 7'(i),
             (i == 7) ? 8'h00 : 8'($urandom), "pre");

    do_txn(2'd2, 1'b0, 1'b1, 7'd30, 8'h3C, "disp_wr");
    do_txn(2'd0, 1'b1, 1'b0, 7'd30, 8'h00, "disp_rd");
    do_txn(2'd3, 1'b1, 1'b1, 7'd10, 8'h77, "rw");
    do_txn(2'd2, 1'b1, 1'b0, 7'd10, 8'h00, "rw_chk");
    do_txn(2'd1, 1'b0, 1'b0, 7'd10, 8'h99, "none");
    do_txn(2'd1, 1'b1, 1'b0, 7'd127, 8'h00, "top");

    if (GUARD) begin
      do_txn(2'd1, 1'b0, 1'b1, 7'd40, 8'hFF, "g_wr");
      do_txn(2'd2, 1'b1, 1'b0, 7'd40, 8'h00, "g_rd");
      do_txn(2'd3, 1'b1, 1'b1, 7'd32, 8'hEE, "g_rw");
      do_txn(2'd0, 1'b0, 1'b1, 7'd40, 8'hFF, "g_p0");
      do_txn(2'd1, 1'b1, 1'b0, 7'd40, 8'h00, "g_p0rd");
    end

    // Randomized traffic biased at display and guard boundaries.
    for (int i = 0; i < 60; i++) begin
      s = 2'($urandom);
      case ($urandom_range(0, 2))
        0: a = 7'($urandom_range(26, 33));
        1: a = 7'($urandom_range(120, 127));
        default: a = 7'($urandom);
      endcase
      do_txn(s, 1'($urandom), 1'($urandom), a,
             8'($urandom), "rnd");
    end

    // en held high: one transaction per P cycles.
    rd_v = '0; wr_v = '0;
    pulses = 0;
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 4 * P; i++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
      sel = 2'(i);
    end
    en = 1'b0;
    chk("busy_rej", 32'(pulses), 32'd4);
    repeat (P) @(negedge clk);
    chk("busy_drain", 32'(busy), 32'd0);
    chk_outs("busy_hold");

    // Reset during ACCESS aborts the write of 0x11 to address 7.
    @(negedge clk);
    rd_v = '0; wr_v = '0;
    wr_v[1] = 1'b1; ad_v[1] = 7'd7; di_v[1] = 8'h11;
    sel = 2'd1; en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    @(negedge clk);
    seen = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | ready;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      od_m[k] = '0; dp_m[k] = '0;
    end
    chk_outs("abort_rst");
    repeat (P) begin
      @(negedge clk);
      seen = seen | ready;
    end
    chk("abort_rdy", 32'(seen), 32'd0);
    do_txn(2'd1, 1'b1, 1'b0, 7'd7, 8'h00, "abort_rd");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
